// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 brute-force key search controller.
// Contents: search_state_t (controller states), KEY_WIDTH_DEFAULT,
// KEYSPACE_LAST_DEFAULT (22-bit search space), TIMEOUT_DEFAULT (watchdog limit).
package rc4_pkg;

  localparam int unsigned KEY_WIDTH_DEFAULT     = 24;
  localparam logic [23:0] KEYSPACE_LAST_DEFAULT = 24'h3FFFFF;
  localparam int unsigned TIMEOUT_DEFAULT       = 4096;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LAUNCH_CORE,
    ST_WAIT_CORE,
    ST_LAUNCH_CHECK,
    ST_WAIT_CHECK,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_EXHAUSTED,
    ST_FAULT
  } search_state_t;

endpackage

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search scheduler. Sweeps candidate keys from KEY_START to
// KEY_LAST, launching the RC4 core then the message checker for each key, and
// stops on the first passing key or when the keyspace is exhausted.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start           level; begins a search from IDLE, releases terminal states when low
//   core_done       RC4 core finished decrypting the current key
//   check_done      checker finished; check_pass is its verdict
//   key             current candidate key (stable from launch until NEXT_KEY)
//   core_start      one-cycle pulse launching the RC4 core
//   check_start     one-cycle pulse launching the checker
//   busy            search in progress
//   found           sticky: key holds the passing key
//   exhausted       sticky: KEY_LAST tried without a pass
//   timeout_err     sticky: core or checker never answered
//
// Build option: define RC4_SEARCH_TIMEOUT_EN to add a watchdog on both wait
// states (TIMEOUT cycles). Without it waits are unbounded and timeout_err is 0.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int unsigned          KEY_WIDTH = KEY_WIDTH_DEFAULT,
  parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST  = KEY_WIDTH'(KEYSPACE_LAST_DEFAULT),
  parameter int unsigned          TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 core_done,
  input  logic                 check_done,
  input  logic                 check_pass,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 core_start,
  output logic                 check_start,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic                 timeout_err
);

  search_state_t state;

`ifdef RC4_SEARCH_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_err    = 1'b0;
`endif

  // Search sequencer; pulses default low so each launch lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      key         <= KEY_START;
      core_start  <= 1'b0;
      check_start <= 1'b0;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
`ifdef RC4_SEARCH_TIMEOUT_EN
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      core_start  <= 1'b0;
      check_start <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            key        <= KEY_START;
            busy       <= 1'b1;
            core_start <= 1'b1;
            state      <= ST_LAUNCH_CORE;
          end
        end

        ST_LAUNCH_CORE: begin
          state <= ST_WAIT_CORE;
`ifdef RC4_SEARCH_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end

        // check_done is deliberately not looked at here.
        ST_WAIT_CORE: begin
          if (core_done) begin
            check_start <= 1'b1;
            state       <= ST_LAUNCH_CHECK;
          end
`ifdef RC4_SEARCH_TIMEOUT_EN
          else if (wd_expired) begin
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_FAULT;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end

        ST_LAUNCH_CHECK: begin
          state <= ST_WAIT_CHECK;
`ifdef RC4_SEARCH_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end

        ST_WAIT_CHECK: begin
          if (check_done) begin
            if (check_pass) begin
              busy  <= 1'b0;
              found <= 1'b1;
              state <= ST_FOUND;
            end else if (key == KEY_LAST) begin
              busy      <= 1'b0;
              exhausted <= 1'b1;
              state     <= ST_EXHAUSTED;
            end else begin
              state <= ST_NEXT_KEY;
            end
          end
`ifdef RC4_SEARCH_TIMEOUT_EN
          else if (wd_expired) begin
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_FAULT;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end

        // KEY_LAST stops the sweep before this increment could wrap.
        ST_NEXT_KEY: begin
          key        <= key + KEY_WIDTH'(1);
          core_start <= 1'b1;
          state      <= ST_LAUNCH_CORE;
        end

        // Terminal states hold their result until start is released.
        ST_FOUND, ST_EXHAUSTED, ST_FAULT: begin
          if (!start) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
`ifdef RC4_SEARCH_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
